// File: rtl/mips_rf_pkg.sv
// Shared types and default sizing for the parametrised MIPS register file.
package mips_rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_t;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NUM_REGS = 32;

endpackage

// File: rtl/mips_regfile_nport_read.sv
// One combinational read port: index decode, zero rules for r0 and
// out-of-range indices, and optional write-through forwarding
// (enabled with MIPS_RF_BYPASS_EN).
module rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  // Registers 1..NUM_REGS-1; entry i lives at bits [(i-1)*DATA_W +: DATA_W]
  input  logic [(NUM_REGS-1)*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]              rd_addr,
`ifdef MIPS_RF_BYPASS_EN
  input  logic                           wr_fire,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
`endif
  output logic [DATA_W-1:0]              rd_data
);

  logic [DATA_W-1:0] stored;

  // Select the stored value; r0 and indices >= NUM_REGS never match and read 0
  always_comb begin
    stored = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        stored = regs_flat[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MIPS_RF_BYPASS_EN
  // wr_fire already excludes r0, out-of-range indices and non-IDLE states
  assign rd_data = (wr_fire && (wr_addr == rd_addr)) ? wr_data : stored;
`else
  assign rd_data = stored;
`endif

endmodule

// File: rtl/mips_regfile_nport.sv
// Parametrised MIPS register file: NUM_RD combinational read ports, one
// write port, r0 hardwired to zero, and a hardware bulk-clear sequencer.
// Define MIPS_RF_BYPASS_EN for same-cycle write-through forwarding.
module mips_regfile_nport
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  rf_clr_state_t state;
  logic [ADDR_W-1:0] idx;

  // r0 has no storage; only 1..NUM_REGS-1 are real flops
  logic [DATA_W-1:0]              regs [1:NUM_REGS-1];
  logic [(NUM_REGS-1)*DATA_W-1:0] regs_flat;

  logic wr_valid;
  logic wr_fire;

  assign wr_valid = (wr_addr != '0) && (32'(wr_addr) < NUM_REGS);
  assign wr_fire  = we && (state == IDLE) && wr_valid;

  // Clear sequencer: IDLE -> CLEAR (idx walks 1..NUM_REGS-1) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= ADDR_W'(1);
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == ADDR_W'(NUM_REGS-1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: reset zeroes all, the sequencer clears regs[idx],
  // otherwise an accepted write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if ((state == CLEAR) && (idx == ADDR_W'(i))) begin
          regs[i] <= '0;
        end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Flatten storage into a bus shared by all read ports
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_flat[(i-1)*DATA_W +: DATA_W] = regs[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_port (
      .regs_flat (regs_flat),
      .rd_addr   (rd_addr[k*ADDR_W +: ADDR_W]),
`ifdef MIPS_RF_BYPASS_EN
      .wr_fire   (wr_fire),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
`endif
      .rd_data   (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_mips_regfile_nport.sv
// Directed bench for mips_regfile_nport: default 32x32 two-port instance
// plus an 8x8 three-port instance for the small-file corner cases.
module tb_mips_regfile_nport;

  logic clk;
  logic rst;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        clr_req;
  logic        busy;
  logic        done;

  logic        we8;
  logic [3:0]  wa8;
  logic [7:0]  wd8;
  logic [11:0] ra8;
  logic [23:0] rd8;
  logic        clr_req8;
  logic        busy8;
  logic        done8;

  int passed = 0;
  int total  = 0;

  mips_regfile_nport #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wa), .wr_data(wd),
    .rd_addr(ra), .rd_data(rd), .clr_req(clr_req),
    .clr_busy(busy), .clr_done(done)
  );

  mips_regfile_nport #(
    .DATA_W(8), .ADDR_W(4), .NUM_REGS(8), .NUM_RD(3)
  ) dut8 (
    .clk(clk), .rst(rst), .we(we8), .wr_addr(wa8), .wr_data(wd8),
    .rd_addr(ra8), .rd_data(rd8), .clr_req(clr_req8),
    .clr_busy(busy8), .clr_done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic peek2(input logic [4:0] a0, input logic [4:0] a1,
                       output logic [31:0] v0, output logic [31:0] v1);
    ra = {a1, a0};
    #1;
    v0 = rd[31:0];
    v1 = rd[63:32];
  endtask

  initial begin
    logic [31:0] v0, v1;
    int busy_cnt, done_cnt;
    logic fin;

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; clr_req = 1'b0;
    we8 = 1'b0; wa8 = '0; wd8 = '0; ra8 = '0; clr_req8 = 1'b0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd1,  32'h11111111, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 5'd5,  32'h55555555, 5'd1,  5'd2,  32'h11111111, 32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  32'h55555555, 32'h11111111};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};

    // Reset state
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      peek2(5'(i), 5'(31 - i), v0, v1);
      chk($sformatf("rst_p0_r%0d", i), v0, 32'h0);
      chk($sformatf("rst_p1_r%0d", 31 - i), v1, 32'h0);
    end

    // Table-driven write/read vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d_p0", i), rd[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), rd[63:32], vecs[i].e1);
    end

    // Same-cycle write and read of r9
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'h00000099;
    @(negedge clk);
    wd = 32'hA5A5A5A5; ra = {5'd8, 5'd9};
    #1;
`ifdef MIPS_RF_BYPASS_EN
    chk("bypass_same_cycle", rd[31:0], 32'hA5A5A5A5);
`else
    chk("no_bypass_same_cycle", rd[31:0], 32'h00000099);
`endif
    chk("bypass_other_port", rd[63:32], 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("r9_next_cycle", rd[31:0], 32'hA5A5A5A5);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(i); wd = 32'(i);
    end
    // Write r20 together with the clear request
    @(negedge clk);
    we = 1'b1; wa = 5'd20; wd = 32'h0000ABCD; clr_req = 1'b1;

    busy_cnt = 0; done_cnt = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("busy_low_in_done", {31'd0, busy}, 32'd0);
        we = 1'b1; wa = 5'd4; wd = 32'h44; clr_req = 1'b1;
        @(negedge clk);
        we = 1'b0; clr_req = 1'b0;
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("no_requeue", {31'd0, busy}, 32'd0);
        fin = 1'b1;
      end else begin
        if (busy_cnt == 1) we = 1'b0;
        if (busy_cnt == 2) clr_req = 1'b0;
        if (busy_cnt == 5) begin
          peek2(5'd20, 5'd5, v0, v1);
          chk("mid_clear_r20", v0, 32'h0000ABCD);
          chk("mid_clear_r5", v1, 32'd5);
          peek2(5'd2, 5'd31, v0, v1);
          chk("mid_clear_r2", v0, 32'h0);
          chk("mid_clear_r31", v1, 32'd31);
        end
        if (busy_cnt == 10) begin
          we = 1'b1; wa = 5'd3; wd = 32'h33;
        end
        if (busy_cnt == 11) we = 1'b0;
      end
    end
    chk("clear_finished", {31'd0, fin}, 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd31);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    @(negedge clk);
    #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      peek2(5'(i), 5'(i), v0, v1);
      chk($sformatf("cleared_r%0d", i), v0, 32'h0);
    end

    // Reset in the middle of a clear
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'd7;
    @(negedge clk);
    wa = 5'd30; wd = 32'd30;
    @(negedge clk);
    we = 1'b0; clr_req = 1'b1;
    busy_cnt = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
      #1;
      if (busy) busy_cnt++;
      if (busy_cnt == 10) begin
        rst = 1'b1;
        fin = 1'b1;
      end
    end
    chk("rst_clear_reached", {31'd0, fin}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    peek2(5'd30, 5'd7, v0, v1);
    chk("rst_mid_r30", v0, 32'h0);
    chk("rst_mid_r7", v1, 32'h0);
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    @(negedge clk);
    we = 1'b0;
    peek2(5'd7, 5'd0, v0, v1);
    chk("write_after_rst", v0, 32'h77);

    // Small file: 8 registers, 3 ports, 8-bit data
    @(negedge clk);
    we8 = 1'b1; wa8 = 4'd12; wd8 = 8'hEE; ra8 = {4'd0, 4'd7, 4'd12};
    #1;
    chk("n8_read_idx12", {8'd0, rd8}, 32'h0);
    @(negedge clk);
    wa8 = 4'd7; wd8 = 8'h7E; ra8 = {4'd12, 4'd4, 4'd0};
    #1;
    chk("n8_idx12_no_alias_r4", {24'd0, rd8[15:8]}, 32'h0);
    chk("n8_idx12_read_after", {24'd0, rd8[23:16]}, 32'h0);
    @(negedge clk);
    we8 = 1'b0; ra8 = {4'd7, 4'd7, 4'd4};
    #1;
    chk("n8_r4", {24'd0, rd8[7:0]}, 32'h0);
    chk("n8_r7_p1", {24'd0, rd8[15:8]}, 32'h7E);
    chk("n8_r7_p2", {24'd0, rd8[23:16]}, 32'h7E);
    @(negedge clk);
    clr_req8 = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      clr_req8 = 1'b0;
      #1;
      if (busy8) busy_cnt++;
      if (done8) done_cnt++;
    end
    chk("n8_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("n8_done_pulses", 32'(done_cnt), 32'd1);
    chk("n8_r7_cleared", {24'd0, rd8[15:8]}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
